axi_burst_master: RTL

Single-outstanding AXI4 burst master that turns a simple command/stream interface into AW/W/B or AR/R transactions. Sits directly upstream of the AXI memory slave and drives its five channels from test sequencers, DMA logic or a CPU bridge. Executes one command at a time: write data enters on a user stream, read data leaves on a user stream, and a one-cycle done pulse reports the response.

---
 rtl/axi_pkg.sv | 39 +++
 rtl/axi_beat_counter.sv | 35 +++
 rtl/axi_burst_master.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI definitions for the burst master: burst/response codes, FSM states, size clamp.
package axi_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_e;

  // Burst attributes captured at command accept and replayed on AW/AR.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } cmd_attr_t;

  function automatic logic [2:0] clamp_size(input logic [2:0] size, input logic [2:0] max_size);
    return (size > max_size) ? max_size : size;
  endfunction

endpackage

// File: rtl/axi_beat_counter.sv
// Beats-remaining counter: loads len, decrements per data handshake, flags the final beat.
// Saturates at zero so a 256-beat burst can never wrap before the master terminates it.
module axi_beat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             is_last_o
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_last_o = (cnt_q == '0);

endmodule

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one command -> AW/W/B or AR/R, then a one-cycle done pulse.
// Latency: cmd accept -> address valid next cycle; last B/R handshake -> done next cycle.
// Backpressure: W/R are combinational pass-throughs; optional watchdog under AXI_MASTER_TIMEOUT_EN.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,
  input  logic [2:0]            cmd_size,
  input  logic [1:0]            cmd_burst,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,
  output logic                  done,
  output logic [1:0]            done_resp,
  output logic                  aw_valid,
  output logic [ADDR_WIDTH-1:0] aw_addr,
  output logic [7:0]            aw_len,
  output logic [2:0]            aw_size,
  output logic [1:0]            aw_burst,
  input  logic                  aw_ready,
  output logic                  w_valid,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [STRB_WIDTH-1:0] w_strb,
  output logic                  w_last,
  input  logic                  w_ready,
  output logic                  b_ready,
  input  logic                  b_valid,
  input  logic [1:0]            b_resp,
  output logic                  ar_valid,
  output logic [ADDR_WIDTH-1:0] ar_addr,
  output logic [7:0]            ar_len,
  output logic [2:0]            ar_size,
  output logic [1:0]            ar_burst,
  input  logic                  ar_ready,
  input  logic                  r_valid,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic [1:0]            r_resp,
  input  logic                  r_last,
  output logic                  r_ready
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(STRB_WIDTH));

  state_e                state_q, state_d;
  cmd_attr_t             cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            resp_q, resp_d;
  logic                  err_q, err_d;
  logic                  cnt_load, cnt_dec, beat_last;
  logic                  to_hit;
  logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, any_hs;

  // Termination follows our own beat count; the slave's r_last is deliberately not trusted.
  logic unused_ok;
  assign unused_ok = &{1'b0, r_last, r_resp[0], TIMEOUT_CYCLES[0]};

  assign aw_hs  = (state_q == ST_AW) & aw_ready & ~to_hit;
  assign w_hs   = (state_q == ST_W)  & wr_valid & w_ready & ~to_hit;
  assign b_hs   = (state_q == ST_B)  & b_valid & ~to_hit;
  assign ar_hs  = (state_q == ST_AR) & ar_ready & ~to_hit;
  assign r_hs   = (state_q == ST_R)  & r_valid & rd_ready & ~to_hit;
  assign any_hs = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  axi_beat_counter #(.WIDTH(8)) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (cmd_len),
    .dec_i      (cnt_dec),
    .is_last_o  (beat_last)
  );

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            to_active;

  assign to_active = (state_q == ST_AW) || (state_q == ST_W) || (state_q == ST_B) ||
                     (state_q == ST_AR) || (state_q == ST_R);
  // Firing on the final counted cycle puts DONE exactly TIMEOUT_CYCLES cycles after the last progress.
  assign to_hit = to_active && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !to_active || any_hs || to_hit) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    resp_d    = resp_q;
    err_d     = err_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    cmd_ready = 1'b0;
    aw_valid  = 1'b0;
    aw_addr   = '0;
    aw_len    = '0;
    aw_size   = '0;
    aw_burst  = '0;
    w_valid   = 1'b0;
    w_data    = '0;
    w_strb    = '0;
    w_last    = 1'b0;
    wr_ready  = 1'b0;
    b_ready   = 1'b0;
    ar_valid  = 1'b0;
    ar_addr   = '0;
    ar_len    = '0;
    ar_size   = '0;
    ar_burst  = '0;
    r_ready   = 1'b0;
    rd_valid  = 1'b0;
    rd_data   = '0;
    rd_last   = 1'b0;
    done      = 1'b0;
    done_resp = '0;

    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid && !rst) begin
          cmd_d.len   = cmd_len;
          cmd_d.size  = clamp_size(cmd_size, MAX_SIZE);
          cmd_d.burst = cmd_burst;
          addr_d      = cmd_addr;
          cnt_load    = 1'b1;
          err_d       = 1'b0;
          resp_d      = RESP_OKAY;
          if (cmd_burst == BURST_RSVD) begin
            resp_d  = RESP_SLVERR;
            state_d = ST_DONE;
          end else begin
            state_d = cmd_write ? ST_AW : ST_AR;
          end
        end
      end
      ST_AW: begin
        aw_valid = ~to_hit;
        aw_addr  = addr_q;
        aw_len   = cmd_q.len;
        aw_size  = cmd_q.size;
        aw_burst = cmd_q.burst;
        if (aw_hs) state_d = ST_W;
      end
      ST_W: begin
        w_valid  = wr_valid & ~to_hit;
        w_data   = wr_data;
        w_strb   = wr_strb;
        w_last   = beat_last;
        wr_ready = w_ready & ~to_hit;
        if (w_hs) begin
          cnt_dec = 1'b1;
          if (beat_last) state_d = ST_B;
        end
      end
      ST_B: begin
        b_ready = ~to_hit;
        if (b_hs) begin
          resp_d  = b_resp;
          state_d = ST_DONE;
        end
      end
      ST_AR: begin
        ar_valid = ~to_hit;
        ar_addr  = addr_q;
        ar_len   = cmd_q.len;
        ar_size  = cmd_q.size;
        ar_burst = cmd_q.burst;
        if (ar_hs) state_d = ST_R;
      end
      ST_R: begin
        rd_valid = r_valid & ~to_hit;
        rd_data  = r_data;
        rd_last  = beat_last;
        r_ready  = rd_ready & ~to_hit;
        if (r_hs) begin
          cnt_dec = 1'b1;
          err_d   = err_q | r_resp[1];
          if (beat_last) begin
            resp_d  = (err_q | r_resp[1]) ? RESP_SLVERR : RESP_OKAY;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        done_resp = resp_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (to_hit) begin
      resp_d  = RESP_DECERR;
      state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      addr_q  <= '0;
      resp_q  <= RESP_OKAY;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

endmodule
